// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift controller: op-codes, FSM states, op helpers.
package shift_seq_ctrl_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
  localparam logic [OP_W-1:0] OP_LSL  = 3'b010;
  localparam logic [OP_W-1:0] OP_LSR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ASR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  // True for the three ops that run through the SHIFT state.
  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_shift_step.sv
// Combinational single-bit shift step; non-shift ops pass the data through unchanged.
module shift_step
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_next
);

  always_comb begin
    d_next = d;
    case (op)
      OP_LSL:  d_next = {d[WIDTH-2:0], 1'b0};
      OP_LSR:  d_next = {1'b0, d[WIDTH-1:1]};
      OP_ASR:  d_next = {d[WIDTH-1], d[WIDTH-1:1]};
      default: d_next = d;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Owns the data register and runs multi-bit shifts one bit per clock behind
// a command handshake, returning the register over a response handshake.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [SHW-1:0]   cmd_shamt,
  input  logic [WIDTH-1:0] cmd_d_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_d_out,
  output logic             busy
);

  state_e           state;
  logic [OP_W-1:0]  op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_step;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .d      (data_q),
    .d_next (data_step)
  );

  assign rsp_d_out = data_q;

  // FSM, counter, data register and handshake flags all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      cnt_q     <= '0;
      data_q    <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_op == OP_LOAD) begin
              data_q <= cmd_d_in;
            end
            if (is_shift_op(cmd_op) && (cmd_shamt != '0)) begin
              cnt_q <= cmd_shamt;
              state <= ST_SHIFT;
            end else begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          data_q <= data_step;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with an expected-result queue checked on each response.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_shamt;
  logic [7:0] cmd_d_in;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_d_out;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  shift_seq_ctrl #(.WIDTH(8), .SHW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_shamt (cmd_shamt),
    .cmd_d_in  (cmd_d_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_d_out (rsp_d_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, wait for its response, check latency/data, then complete the handshake.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] sh, input logic [7:0] d,
                         input logic [7:0] exp_val, input int hold, input bit junk);
    int lat;
    int exp_lat;
    logic [7:0] want;
    exp_q.push_back(exp_val);
    exp_lat = ((op == 3'd2 || op == 3'd3 || op == 3'd4) && sh != 3'd0) ? int'(sh) + 1 : 1;
    chk("cmd_ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_shamt = sh;
    cmd_d_in  = d;
    tick();
    lat = 1;
    if (junk) begin
      cmd_op    = 3'b001;
      cmd_shamt = 3'd0;
      cmd_d_in  = 8'h00;
    end else begin
      cmd_valid = 1'b0;
    end
    while (!rsp_valid && lat < 64) begin
      chk("busy_in_shift", 32'(busy), 32'd1);
      tick();
      lat++;
    end
    cmd_valid = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      chk("queue_nonempty", 32'd0, 32'd1);
      want = 8'hxx;
    end else begin
      want = exp_q.pop_front();
    end
    chk("rsp_d_out", 32'(rsp_d_out), 32'(want));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_d_out), 32'(want));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_shamt = 3'd0;
    cmd_d_in  = 8'h00;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_d_out", 32'(rsp_d_out), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);

    run_cmd(3'b001, 3'd0, 8'hFF, 8'hFF, 3, 1'b0);
    run_cmd(3'b001, 3'd0, 8'h55, 8'h55, 0, 1'b0);
    run_cmd(3'b010, 3'd1, 8'h00, 8'hAA, 0, 1'b0);
    run_cmd(3'b011, 3'd2, 8'h00, 8'h2A, 0, 1'b0);
    run_cmd(3'b001, 3'd0, 8'h80, 8'h80, 0, 1'b0);
    run_cmd(3'b100, 3'd3, 8'h00, 8'hF0, 0, 1'b0);
    run_cmd(3'b001, 3'd0, 8'hFF, 8'hFF, 0, 1'b0);
    run_cmd(3'b100, 3'd7, 8'h00, 8'hFF, 1, 1'b0);
    run_cmd(3'b001, 3'd0, 8'h3C, 8'h3C, 0, 1'b0);
    run_cmd(3'b010, 3'd0, 8'h00, 8'h3C, 0, 1'b0);
    run_cmd(3'b111, 3'd5, 8'h99, 8'h3C, 0, 1'b0);
    run_cmd(3'b000, 3'd3, 8'h11, 8'h3C, 0, 1'b0);
    run_cmd(3'b010, 3'd7, 8'h00, 8'h00, 0, 1'b0);
    // A LOAD kept on the command port while busy must not disturb the shift.
    run_cmd(3'b001, 3'd0, 8'h81, 8'h81, 0, 1'b0);
    run_cmd(3'b011, 3'd3, 8'h00, 8'h10, 2, 1'b1);
    run_cmd(3'b001, 3'd0, 8'hC3, 8'hC3, 0, 1'b0);
    run_cmd(3'b100, 3'd1, 8'h00, 8'hE1, 0, 1'b0);

    // Reset during the second SHIFT cycle aborts the command.
    run_cmd(3'b001, 3'd0, 8'hF0, 8'hF0, 0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 3'b011;
    cmd_shamt = 3'd5;
    tick();
    cmd_valid = 1'b0;
    chk("abort_busy_1", 32'(busy), 32'd1);
    tick();
    chk("abort_data_1", 32'(rsp_d_out), 32'h78);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_data", 32'(rsp_d_out), 32'h00);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_cmd(3'b000, 3'd0, 8'h00, 8'h00, 0, 1'b0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
